// File: rtl/alu_rs_if.sv
// Dispatch, common-data-bus and ALU-issue signal bundle for the ALU reservation station.
// The master side is the dispatcher/broadcasters/ALU, the slave side is the station.
interface alu_rs_if #(
  parameter int ROB_W = 4
);
  logic             iss_valid;
  logic [6:0]       iss_opcode;
  logic [2:0]       iss_funct3;
  logic             iss_funct7;
  logic [31:0]      iss_imm;
  logic [31:0]      iss_pc;
  logic [ROB_W-1:0] iss_rob_pos;
  logic             iss_q1_rdy;
  logic [31:0]      iss_v1;
  logic [ROB_W-1:0] iss_q1;
  logic             iss_q2_rdy;
  logic [31:0]      iss_v2;
  logic [ROB_W-1:0] iss_q2;

  logic             alu_cdb_valid;
  logic [ROB_W-1:0] alu_cdb_rob;
  logic [31:0]      alu_cdb_val;
  logic             lsb_cdb_valid;
  logic [ROB_W-1:0] lsb_cdb_rob;
  logic [31:0]      lsb_cdb_val;

  logic             rs_full;

  logic             alu_en;
  logic [6:0]       alu_opcode;
  logic [2:0]       alu_funct3;
  logic             alu_funct7;
  logic [31:0]      alu_val1;
  logic [31:0]      alu_val2;
  logic [31:0]      alu_imm;
  logic [ROB_W-1:0] alu_rob_pos;
  logic [31:0]      alu_pc;

  modport master (
    output iss_valid, iss_opcode, iss_funct3, iss_funct7, iss_imm, iss_pc, iss_rob_pos,
    output iss_q1_rdy, iss_v1, iss_q1, iss_q2_rdy, iss_v2, iss_q2,
    output alu_cdb_valid, alu_cdb_rob, alu_cdb_val, lsb_cdb_valid, lsb_cdb_rob, lsb_cdb_val,
    input  rs_full,
    input  alu_en, alu_opcode, alu_funct3, alu_funct7, alu_val1, alu_val2, alu_imm,
    input  alu_rob_pos, alu_pc
  );

  modport slave (
    input  iss_valid, iss_opcode, iss_funct3, iss_funct7, iss_imm, iss_pc, iss_rob_pos,
    input  iss_q1_rdy, iss_v1, iss_q1, iss_q2_rdy, iss_v2, iss_q2,
    input  alu_cdb_valid, alu_cdb_rob, alu_cdb_val, lsb_cdb_valid, lsb_cdb_rob, lsb_cdb_val,
    output rs_full,
    output alu_en, alu_opcode, alu_funct3, alu_funct7, alu_val1, alu_val2, alu_imm,
    output alu_rob_pos, alu_pc
  );
endinterface

// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ops until both operands are captured from
// the CDBs, then issues the lowest-index ready entry to the ALU, one per cycle.
module alu_rs #(
  parameter int RS_SIZE = 8,
  parameter int ROB_W   = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     rdy,
  input  logic     rollback,
  alu_rs_if.slave  rs
);
  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  logic [RS_SIZE-1:0] busy;
  logic [RS_SIZE-1:0] r1;
  logic [RS_SIZE-1:0] r2;
  logic [RS_SIZE-1:0] ready;
  logic [6:0]         opcode  [RS_SIZE];
  logic [2:0]         funct3  [RS_SIZE];
  logic               funct7  [RS_SIZE];
  logic [31:0]        imm     [RS_SIZE];
  logic [31:0]        pc      [RS_SIZE];
  logic [ROB_W-1:0]   rob_pos [RS_SIZE];
  logic [31:0]        v1      [RS_SIZE];
  logic [31:0]        v2      [RS_SIZE];
  logic [ROB_W-1:0]   q1      [RS_SIZE];
  logic [ROB_W-1:0]   q2      [RS_SIZE];

  logic [RS_SIZE-1:0] w1_hit;
  logic [RS_SIZE-1:0] w2_hit;
  logic [31:0]        w1_val [RS_SIZE];
  logic [31:0]        w2_val [RS_SIZE];
  logic               d_hit1, d_hit2;
  logic [31:0]        d_val1, d_val2;
  logic               d_r1, d_r2;
  logic [31:0]        d_v1, d_v2;

  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   issue_idx;
  logic               issue_any;
  logic               step_en;
  logic               dispatch_en;

  // Tag match against both broadcast buses; the ALU bus wins a same-tag collision.
  function automatic logic [32:0] snoop(
    input logic [ROB_W-1:0] q,
    input logic             a_valid,
    input logic [ROB_W-1:0] a_rob,
    input logic [31:0]      a_val,
    input logic             l_valid,
    input logic [ROB_W-1:0] l_rob,
    input logic [31:0]      l_val
  );
    if (a_valid && (a_rob == q))      return {1'b1, a_val};
    else if (l_valid && (l_rob == q)) return {1'b1, l_val};
    else                              return {1'b0, 32'h0};
  endfunction

  assign step_en     = rdy && !rollback;
  assign ready       = busy & r1 & r2;
  assign rs.rs_full  = &busy;
  assign dispatch_en = step_en && rs.iss_valid && !rs.rs_full;

  always_comb begin
    free_idx  = '0;
    issue_idx = '0;
    issue_any = 1'b0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy[i]) free_idx = IDX_W'(i);
      if (ready[i]) begin
        issue_idx = IDX_W'(i);
        issue_any = 1'b1;
      end
    end
  end

  always_comb begin
    w1_hit = '0;
    w2_hit = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      {w1_hit[i], w1_val[i]} = snoop(q1[i], rs.alu_cdb_valid, rs.alu_cdb_rob, rs.alu_cdb_val,
                                     rs.lsb_cdb_valid, rs.lsb_cdb_rob, rs.lsb_cdb_val);
      {w2_hit[i], w2_val[i]} = snoop(q2[i], rs.alu_cdb_valid, rs.alu_cdb_rob, rs.alu_cdb_val,
                                     rs.lsb_cdb_valid, rs.lsb_cdb_rob, rs.lsb_cdb_val);
    end
    {d_hit1, d_val1} = snoop(rs.iss_q1, rs.alu_cdb_valid, rs.alu_cdb_rob, rs.alu_cdb_val,
                             rs.lsb_cdb_valid, rs.lsb_cdb_rob, rs.lsb_cdb_val);
    {d_hit2, d_val2} = snoop(rs.iss_q2, rs.alu_cdb_valid, rs.alu_cdb_rob, rs.alu_cdb_val,
                             rs.lsb_cdb_valid, rs.lsb_cdb_rob, rs.lsb_cdb_val);
    d_r1 = rs.iss_q1_rdy || d_hit1;
    d_r2 = rs.iss_q2_rdy || d_hit2;
    d_v1 = rs.iss_q1_rdy ? rs.iss_v1 : d_val1;
    d_v2 = rs.iss_q2_rdy ? rs.iss_v2 : d_val2;
  end

  // Control state and issue register: busy bits and alu_* outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy           <= '0;
      rs.alu_en      <= 1'b0;
      rs.alu_opcode  <= '0;
      rs.alu_funct3  <= '0;
      rs.alu_funct7  <= 1'b0;
      rs.alu_val1    <= '0;
      rs.alu_val2    <= '0;
      rs.alu_imm     <= '0;
      rs.alu_rob_pos <= '0;
      rs.alu_pc      <= '0;
    end else if (rdy) begin
      if (rollback) begin
        busy      <= '0;
        rs.alu_en <= 1'b0;
      end else begin
        rs.alu_en <= issue_any;
        if (issue_any) begin
          busy[issue_idx] <= 1'b0;
          rs.alu_opcode   <= opcode[issue_idx];
          rs.alu_funct3   <= funct3[issue_idx];
          rs.alu_funct7   <= funct7[issue_idx];
          rs.alu_val1     <= v1[issue_idx];
          rs.alu_val2     <= v2[issue_idx];
          rs.alu_imm      <= imm[issue_idx];
          rs.alu_rob_pos  <= rob_pos[issue_idx];
          rs.alu_pc       <= pc[issue_idx];
        end
        if (dispatch_en) busy[free_idx] <= 1'b1;
      end
    end
  end

  // Entry payload: operand wakeup and dispatch write; meaningless while busy is clear.
  always_ff @(posedge clk) begin
    if (step_en) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy[i] && !r1[i] && w1_hit[i]) begin
          v1[i] <= w1_val[i];
          r1[i] <= 1'b1;
        end
        if (busy[i] && !r2[i] && w2_hit[i]) begin
          v2[i] <= w2_val[i];
          r2[i] <= 1'b1;
        end
      end
      if (dispatch_en) begin
        opcode[free_idx]  <= rs.iss_opcode;
        funct3[free_idx]  <= rs.iss_funct3;
        funct7[free_idx]  <= rs.iss_funct7;
        imm[free_idx]     <= rs.iss_imm;
        pc[free_idx]      <= rs.iss_pc;
        rob_pos[free_idx] <= rs.iss_rob_pos;
        q1[free_idx]      <= rs.iss_q1;
        q2[free_idx]      <= rs.iss_q2;
        v1[free_idx]      <= d_v1;
        v2[free_idx]      <= d_v2;
        r1[free_idx]      <= d_r1;
        r2[free_idx]      <= d_r2;
      end
    end
  end
endmodule

// File: tb/tb_alu_rs.sv
// Bench for alu_rs: directed scenarios plus randomized traffic, every cycle compared
// against a behavioural reservation-station model held in an array of entries.
module tb_alu_rs;
  localparam int RS_SIZE = 8;
  localparam int ROB_W   = 4;

  logic clk;
  logic rst;
  logic rdy;
  logic rollback;

  alu_rs_if #(.ROB_W(ROB_W)) bus ();

  alu_rs #(.RS_SIZE(RS_SIZE), .ROB_W(ROB_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .rollback (rollback),
    .rs       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        busy;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [3:0]  rob;
    logic        r1;
    logic [31:0] v1;
    logic [3:0]  q1;
    logic        r2;
    logic [31:0] v2;
    logic [3:0]  q2;
  } ent_t;

  ent_t        m [RS_SIZE];
  logic        m_en;
  logic [6:0]  m_op;
  logic [2:0]  m_f3;
  logic        m_f7;
  logic [31:0] m_v1, m_v2, m_imm, m_pc;
  logic [3:0]  m_rob;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic model_full();
    logic f = 1'b1;
    for (int i = 0; i < RS_SIZE; i++) f = f & m[i].busy;
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < RS_SIZE; i++) m[i] = '0;
    m_en = 0; m_op = 0; m_f3 = 0; m_f7 = 0;
    m_v1 = 0; m_v2 = 0; m_imm = 0; m_pc = 0; m_rob = 0;
  endtask

  // Value an operand waiting on tag q would pick up from this cycle's broadcasts.
  function automatic logic [32:0] bcast(input logic [3:0] q);
    if (bus.alu_cdb_valid && bus.alu_cdb_rob == q) return {1'b1, bus.alu_cdb_val};
    if (bus.lsb_cdb_valid && bus.lsb_cdb_rob == q) return {1'b1, bus.lsb_cdb_val};
    return 33'h0;
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    ent_t        old [RS_SIZE];
    int          k;
    int          f;
    logic [32:0] b;
    ent_t        e;
    if (!rdy) return;
    if (rollback) begin
      for (int i = 0; i < RS_SIZE; i++) m[i].busy = 1'b0;
      m_en = 1'b0;
      return;
    end
    old = m;
    k = -1;
    f = -1;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (old[i].busy && old[i].r1 && old[i].r2) k = i;
      if (!old[i].busy) f = i;
    end
    for (int i = 0; i < RS_SIZE; i++) begin
      if (old[i].busy && !old[i].r1) begin
        b = bcast(old[i].q1);
        if (b[32]) begin m[i].r1 = 1'b1; m[i].v1 = b[31:0]; end
      end
      if (old[i].busy && !old[i].r2) begin
        b = bcast(old[i].q2);
        if (b[32]) begin m[i].r2 = 1'b1; m[i].v2 = b[31:0]; end
      end
    end
    if (k >= 0) begin
      m_en = 1'b1; m_op = old[k].op; m_f3 = old[k].f3; m_f7 = old[k].f7;
      m_v1 = old[k].v1; m_v2 = old[k].v2; m_imm = old[k].imm; m_pc = old[k].pc;
      m_rob = old[k].rob;
      m[k].busy = 1'b0;
    end else begin
      m_en = 1'b0;
    end
    if (bus.iss_valid && f >= 0) begin
      e = '0;
      e.busy = 1'b1; e.op = bus.iss_opcode; e.f3 = bus.iss_funct3; e.f7 = bus.iss_funct7;
      e.imm = bus.iss_imm; e.pc = bus.iss_pc; e.rob = bus.iss_rob_pos;
      e.q1 = bus.iss_q1; e.q2 = bus.iss_q2;
      if (bus.iss_q1_rdy) begin e.r1 = 1'b1; e.v1 = bus.iss_v1; end
      else begin b = bcast(bus.iss_q1); e.r1 = b[32]; e.v1 = b[31:0]; end
      if (bus.iss_q2_rdy) begin e.r2 = 1'b1; e.v2 = bus.iss_v2; end
      else begin b = bcast(bus.iss_q2); e.r2 = b[32]; e.v2 = b[31:0]; end
      m[f] = e;
    end
  endtask

  task automatic check_outs();
    chk("alu_en",      32'(bus.alu_en),      32'(m_en));
    chk("alu_opcode",  32'(bus.alu_opcode),  32'(m_op));
    chk("alu_funct3",  32'(bus.alu_funct3),  32'(m_f3));
    chk("alu_funct7",  32'(bus.alu_funct7),  32'(m_f7));
    chk("alu_val1",    bus.alu_val1,         m_v1);
    chk("alu_val2",    bus.alu_val2,         m_v2);
    chk("alu_imm",     bus.alu_imm,          m_imm);
    chk("alu_rob_pos", 32'(bus.alu_rob_pos), 32'(m_rob));
    chk("alu_pc",      bus.alu_pc,           m_pc);
  endtask

  task automatic cycle();
    chk("rs_full", 32'(bus.rs_full), 32'(model_full()));
    model_step();
    @(posedge clk);
    #1;
    check_outs();
  endtask

  task automatic idle();
    rdy = 1'b1;
    rollback = 1'b0;
    bus.iss_valid = 1'b0;
    bus.alu_cdb_valid = 1'b0;
    bus.lsb_cdb_valid = 1'b0;
  endtask

  task automatic disp(input logic [6:0] op, input logic [3:0] rob,
                      input logic q1r, input logic [31:0] v1, input logic [3:0] q1,
                      input logic q2r, input logic [31:0] v2, input logic [3:0] q2,
                      input logic [31:0] imm);
    bus.iss_valid   = 1'b1;
    bus.iss_opcode  = op;
    bus.iss_funct3  = rob[2:0];
    bus.iss_funct7  = rob[0];
    bus.iss_imm     = imm;
    bus.iss_pc      = 32'h1000 + {26'h0, rob, 2'b00};
    bus.iss_rob_pos = rob;
    bus.iss_q1_rdy  = q1r;
    bus.iss_v1      = v1;
    bus.iss_q1      = q1;
    bus.iss_q2_rdy  = q2r;
    bus.iss_v2      = v2;
    bus.iss_q2      = q2;
  endtask

  task automatic acdb(input logic [3:0] rob, input logic [31:0] val);
    bus.alu_cdb_valid = 1'b1; bus.alu_cdb_rob = rob; bus.alu_cdb_val = val;
  endtask

  task automatic lcdb(input logic [3:0] rob, input logic [31:0] val);
    bus.lsb_cdb_valid = 1'b1; bus.lsb_cdb_rob = rob; bus.lsb_cdb_val = val;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_REG = 7'b0110011;

  initial begin
    rst = 1'b0;
    idle();
    disp(7'h0, 4'h0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0, 32'h0);
    bus.iss_valid = 1'b0;
    bus.alu_cdb_rob = 0; bus.alu_cdb_val = 0; bus.lsb_cdb_rob = 0; bus.lsb_cdb_val = 0;
    model_reset();
    #2 rst = 1'b1;
    #1;
    chk("reset_rs_full", 32'(bus.rs_full), 32'h0);
    check_outs();
    #9 rst = 1'b0;

    // ADDI with ready operand: stored, then issued the following edge.
    idle();
    disp(OP_IMM, 4'd3, 1'b1, 32'd5, 4'd0, 1'b1, 32'd0, 4'd0, 32'd7);
    cycle();
    chk("addi_not_yet", 32'(bus.alu_en), 32'h0);
    idle();
    cycle();
    chk("addi_en", 32'(bus.alu_en), 32'h1);
    chk("addi_rob", 32'(bus.alu_rob_pos), 32'd3);
    chk("addi_val1", bus.alu_val1, 32'd5);
    chk("addi_imm", bus.alu_imm, 32'd7);

    // ADD waiting on tag 5 woken by the ALU bus after two idle cycles.
    idle();
    disp(OP_REG, 4'd2, 1'b1, 32'd1, 4'd0, 1'b0, 32'd0, 4'd5, 32'd0);
    cycle();
    idle(); cycle();
    idle(); cycle();
    idle(); acdb(4'd5, 32'h10);
    cycle();
    chk("add_wake_edge", 32'(bus.alu_en), 32'h0);
    idle();
    cycle();
    chk("add_en", 32'(bus.alu_en), 32'h1);
    chk("add_val2", bus.alu_val2, 32'h10);

    // Dispatch-cycle bypass from the LSB bus.
    idle();
    disp(OP_REG, 4'd7, 1'b0, 32'd0, 4'd6, 1'b1, 32'd2, 4'd0, 32'd0);
    lcdb(4'd6, 32'hAB);
    cycle();
    idle();
    cycle();
    chk("bypass_en", 32'(bus.alu_en), 32'h1);
    chk("bypass_val1", bus.alu_val1, 32'hAB);

    // Fill all entries with ops waiting on tags 8..15.
    for (int i = 0; i < RS_SIZE; i++) begin
      idle();
      disp(OP_REG, 4'(i), 1'b0, 32'd0, 4'(8 + i), 1'b1, 32'(i), 4'd0, 32'(i));
      cycle();
    end
    chk("full_set", 32'(bus.rs_full), 32'h1);
    idle();
    disp(OP_IMM, 4'd9, 1'b1, 32'h99, 4'd0, 1'b1, 32'd0, 4'd0, 32'd0);
    cycle();
    idle(); cycle();
    chk("full_ignored", 32'(bus.alu_en), 32'h0);
    idle(); acdb(4'd12, 32'h44);
    cycle();
    idle();
    chk("full_before_issue", 32'(bus.rs_full), 32'h1);
    cycle();
    chk("e4_en", 32'(bus.alu_en), 32'h1);
    chk("e4_rob", 32'(bus.alu_rob_pos), 32'd4);
    chk("e4_val1", bus.alu_val1, 32'h44);
    chk("full_cleared", 32'(bus.rs_full), 32'h0);
    idle();
    disp(OP_IMM, 4'd13, 1'b1, 32'h55, 4'd0, 1'b1, 32'd0, 4'd0, 32'd1);
    cycle();
    chk("refill_full", 32'(bus.rs_full), 32'h1);
    idle(); cycle();
    chk("refill_rob", 32'(bus.alu_rob_pos), 32'd13);

    // Clear, then two entries become ready together: lower index goes first.
    idle(); rollback = 1'b1; cycle();
    for (int i = 0; i < 6; i++) begin
      idle();
      disp(OP_REG, 4'(i + 1), 1'b0, 32'd0, 4'(8 + i), 1'b1, 32'd0, 4'd0, 32'd0);
      cycle();
    end
    idle(); acdb(4'd13, 32'h5); lcdb(4'd9, 32'h1);
    cycle();
    idle(); cycle();
    chk("prio_first", 32'(bus.alu_rob_pos), 32'd2);
    idle(); acdb(4'd10, 32'h3);
    cycle();
    chk("prio_second", 32'(bus.alu_rob_pos), 32'd6);
    idle(); rollback = 1'b1;
    disp(OP_IMM, 4'd14, 1'b1, 32'd0, 4'd0, 1'b1, 32'd0, 4'd0, 32'd0);
    acdb(4'd8, 32'h7);
    cycle();
    chk("rollback_en", 32'(bus.alu_en), 32'h0);
    chk("rollback_full", 32'(bus.rs_full), 32'h0);
    idle(); acdb(4'd8, 32'h7); cycle();
    idle(); cycle();

    // Asynchronous reset with four busy entries and a live issue.
    for (int i = 0; i < 4; i++) begin
      idle();
      disp(OP_REG, 4'(i), 1'b0, 32'd0, 4'(8 + i), 1'b1, 32'd0, 4'd0, 32'd0);
      cycle();
    end
    idle(); disp(OP_IMM, 4'd5, 1'b1, 32'h77, 4'd0, 1'b1, 32'd0, 4'd0, 32'd0);
    cycle();
    idle(); cycle();
    chk("pre_reset_en", 32'(bus.alu_en), 32'h1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("rst_en", 32'(bus.alu_en), 32'h0);
    chk("rst_full", 32'(bus.rs_full), 32'h0);
    check_outs();
    @(negedge clk);
    rst = 1'b0;

    // rdy low freezes everything, including a pending alu_en.
    idle(); disp(OP_IMM, 4'd1, 1'b1, 32'h11, 4'd0, 1'b1, 32'd0, 4'd0, 32'd0);
    cycle();
    idle(); cycle();
    chk("hold_pre_en", 32'(bus.alu_en), 32'h1);
    for (int i = 0; i < 3; i++) begin
      idle(); rdy = 1'b0; rollback = (i == 1);
      disp(OP_IMM, 4'd2, 1'b1, 32'h22, 4'd0, 1'b1, 32'd0, 4'd0, 32'd0);
      acdb(4'd3, 32'h1);
      cycle();
      chk("hold_en", 32'(bus.alu_en), 32'h1);
    end
    idle(); cycle();
    chk("hold_release_en", 32'(bus.alu_en), 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      idle();
      rdy = ($urandom_range(0, 9) != 0);
      rollback = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 1) == 1)
        disp(7'($urandom), 4'($urandom),
             ($urandom_range(0, 9) < 6), $urandom, 4'($urandom),
             ($urandom_range(0, 9) < 6), $urandom, 4'($urandom), $urandom);
      if ($urandom_range(0, 2) == 0) acdb(4'($urandom), $urandom);
      if ($urandom_range(0, 2) == 0) lcdb(4'($urandom), $urandom);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
